// File: rtl/pc_fetch.sv
// Program counter and next-PC select for the single-cycle MIPS fetch stage.
// Latency: a redirect presented in cycle N is on Address in cycle N+1, with no bubbles.
// Backpressure: stall=1 freezes PC, state and counter; HALT/FAULT freeze everything until reset.
//
// Ports:
//   clock, reset        - rising-edge clock; synchronous active-low reset
//   stall               - hold all state this cycle
//   instr               - instruction fetched from Address (checked for the halt encoding)
//   branch_taken/imm    - PC-relative branch, offset in words
//   jump/jump_index     - J/JAL pseudo-direct target
//   jump_reg/reg_target - JR target taken verbatim
//   Address, pc_plus4   - current PC and PC+4 (combinational)
//   halted, fault       - registered state flags
//   instr_count         - saturating retired-instruction counter
module pc_fetch #(
  parameter int                  WIDTH     = 32,
  parameter logic [WIDTH-1:0]    RESET_PC  = 32'h00000000,
  parameter int                  MEM_WORDS = 64,
  parameter logic [WIDTH-1:0]    HALT_WORD = 32'hFC000000,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_imm,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jump_reg,
  input  logic [WIDTH-1:0]     reg_target,
  output logic [WIDTH-1:0]     Address,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // First byte address past the end of instruction memory.
  localparam logic [WIDTH-1:0] PC_LIMIT = WIDTH'(MEM_WORDS) << 2;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 halted_q, halted_d;
  logic                 fault_q, fault_d;

  logic [WIDTH-1:0]     branch_tgt;
  logic [WIDTH-1:0]     jump_tgt;
  logic [WIDTH-1:0]     next_pc;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign pc_plus4   = addr_q + WIDTH'(4);
  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign branch_tgt = pc_plus4 + {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
  // Pseudo-direct jump keeps the top nibble of the sequential PC.
  assign jump_tgt   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = reg_target;
    end else if (jump) begin
      next_pc = jump_tgt;
    end else if (branch_taken) begin
      next_pc = branch_tgt;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (state_q == ST_RUN && !stall) begin
      if (instr == HALT_WORD) begin
        // Halt retires but does not advance, so Address rests on the halt word.
        state_d  = ST_HALT;
        halted_d = 1'b1;
        cnt_d    = cnt_inc;
      end else if (next_pc[1:0] != 2'b00 || next_pc >= PC_LIMIT) begin
        // Faulting instruction is not retired; Address keeps pointing at it.
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        addr_d = next_pc;
        cnt_d  = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      addr_q   <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign Address     = addr_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule
